// File: rtl/lcd_clken_gen.sv
`default_nettype none
// =============================================================================
// Module   : lcd_clken_gen
// Summary  : N-channel divided clock-enable generator with PLL-style lock
//            supervision; optional clk_div square waves (LCD_CLKEN_DUTY_EN).
// Revision : 1.0 - initial release
// =============================================================================
module lcd_clken_gen #(
    parameter int                      NUM_CH      = 3,
    parameter int                      DIV_W       = 8,
    parameter int                      LOCK_CYCLES = 64,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = {8'd20, 8'd10, 8'd30},
    localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_ready,
    output logic              locked,
`ifdef LCD_CLKEN_DUTY_EN
    output logic [NUM_CH-1:0] clk_div,
`endif
    output logic [NUM_CH-1:0] clken
);

    localparam int              SC_W        = $clog2(LOCK_CYCLES);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(LOCK_CYCLES - 1);
    localparam logic [CH_W:0]   CH_LIMIT    = (CH_W + 1)'(NUM_CH);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic              locked_q, locked_d;
    logic [NUM_CH-1:0] clken_q, clken_d;
    logic [DIV_W-1:0]  div_q   [NUM_CH];
    logic [DIV_W-1:0]  div_d   [NUM_CH];
    logic [DIV_W-1:0]  phase_q [NUM_CH];
    logic [DIV_W-1:0]  phase_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q   [NUM_CH];
    logic [DIV_W-1:0]  cnt_d   [NUM_CH];

    logic              w_wr_accept;
    logic [DIV_W-1:0]  w_last      [NUM_CH];
    logic [DIV_W-1:0]  w_phase_eff [NUM_CH];

`ifdef LCD_CLKEN_DUTY_EN
    logic [NUM_CH-1:0] clk_div_q, clk_div_d;
    logic [DIV_W:0]    w_half [NUM_CH];
`endif

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = '0;
        w_wr_accept  = cfg_we && locked_q && ({1'b0, cfg_ch} < CH_LIMIT);

        case (state_q)
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_LOCKED;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_wr_accept) begin
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_SETTLE;
        endcase

        locked_d = (state_d == ST_LOCKED);

        // Counters only advance across two consecutive LOCKED cycles, so every
        // lock starts with all channels at zero and therefore phase-aligned.
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]   = div_q[i];
            phase_d[i] = phase_q[i];
            if (w_wr_accept && (cfg_ch == CH_W'(i))) begin
                div_d[i]   = cfg_div;
                phase_d[i] = cfg_phase;
            end
            w_last[i]      = (div_d[i] == '0) ? '0 : div_d[i] - 1'b1;
            w_phase_eff[i] = (phase_d[i] > w_last[i]) ? w_last[i] : phase_d[i];
            cnt_d[i]       = '0;
            if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) begin
                cnt_d[i] = (cnt_q[i] >= w_last[i]) ? '0 : cnt_q[i] + 1'b1;
            end
            clken_d[i] = locked_d && (cnt_d[i] == w_phase_eff[i]);
        end
    end

`ifdef LCD_CLKEN_DUTY_EN
    // High for the first ceil(div_eff/2) counts of each period.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_half[i]    = ({1'b0, w_last[i]} + (DIV_W + 1)'(2)) >> 1;
            clk_div_d[i] = locked_d && ({1'b0, cnt_d[i]} < w_half[i]);
        end
    end
`endif

    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            locked_q     <= 1'b0;
            clken_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
`ifdef LCD_CLKEN_DUTY_EN
            clk_div_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            locked_q     <= locked_d;
            clken_q      <= clken_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
`ifdef LCD_CLKEN_DUTY_EN
            clk_div_q    <= clk_div_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign cfg_ready = locked_q;
    assign clken     = clken_q;
`ifdef LCD_CLKEN_DUTY_EN
    assign clk_div   = clk_div_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_clken_gen.sv
`default_nettype none
// =============================================================================
// Module   : tb_lcd_clken_gen
// Summary  : Self-checking bench for lcd_clken_gen against a cycle-count model.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_lcd_clken_gen;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int LOCK_CYCLES = 64;
    localparam int CH_W        = 2;

    logic              refclk    = 1'b0;
    logic              reset_n   = 1'b0;
    logic              cfg_we    = 1'b0;
    logic [CH_W-1:0]   cfg_ch    = '0;
    logic [DIV_W-1:0]  cfg_div   = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic              cfg_ready;
    logic              locked;
    logic [NUM_CH-1:0] clken;
`ifdef LCD_CLKEN_DUTY_EN
    logic [NUM_CH-1:0] clk_div;
`endif

    always #5 refclk = ~refclk;

    lcd_clken_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DIV_INIT    ({8'd20, 8'd10, 8'd30})
    ) dut (
        .refclk    (refclk),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_ready (cfg_ready),
        .locked    (locked),
`ifdef LCD_CLKEN_DUTY_EN
        .clk_div   (clk_div),
`endif
        .clken     (clken)
    );

    int checks    = 0;
    int failures  = 0;
    int n         = 0;           // rising edges seen
    int lock_edge = 32'h3fff_ffff; // edge after which locked is high
    int mdiv   [NUM_CH];
    int mphase [NUM_CH];

    // Model: locked after edge lock_edge; LOCKED cycle t = n - lock_edge.
    function automatic void model_reset();
        mdiv[0] = 30; mdiv[1] = 10; mdiv[2] = 20;
        for (int i = 0; i < NUM_CH; i++) mphase[i] = 0;
    endfunction

    function automatic int deff(int i);
        return (mdiv[i] == 0) ? 1 : mdiv[i];
    endfunction

    function automatic int peff(int i);
        return (mphase[i] > deff(i) - 1) ? deff(i) - 1 : mphase[i];
    endfunction

    function automatic logic exp_locked();
        return n >= lock_edge;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_clken();
        logic [NUM_CH-1:0] v;
        v = '0;
        if (n >= lock_edge)
            for (int i = 0; i < NUM_CH; i++) v[i] = (((n - lock_edge) % deff(i)) == peff(i));
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_clkdiv();
        logic [NUM_CH-1:0] v;
        v = '0;
        if (n >= lock_edge)
            for (int i = 0; i < NUM_CH; i++) v[i] = (((n - lock_edge) % deff(i)) < ((deff(i) + 1) / 2));
        return v;
    endfunction

    // Advance one edge, update the model from the inputs seen at that edge,
    // and return at the following falling edge for sampling.
    task automatic step();
        logic was_locked;
        was_locked = (n >= lock_edge);
        @(posedge refclk);
        n++;
        if (!reset_n) begin
            model_reset();
            lock_edge = n + LOCK_CYCLES;
        end else if (cfg_we && was_locked && (int'(cfg_ch) < NUM_CH)) begin
            mdiv[cfg_ch]   = int'(cfg_div);
            mphase[cfg_ch] = int'(cfg_phase);
            lock_edge      = n + LOCK_CYCLES;
        end
        @(negedge refclk);
    endtask

    task automatic test_reset();
        int first_hi;
        first_hi = -1;
        reset_n = 1'b0;
        repeat (2 + $urandom_range(0, 3)) step();
        checks++;
        if (locked !== 1'b0 || cfg_ready !== 1'b0 || clken !== '0) begin
            failures++;
            $display("FAIL reset_state locked=%b ready=%b clken=%b want 0/0/000", locked, cfg_ready, clken);
        end
        reset_n = 1'b1;
        for (int c = 0; c < LOCK_CYCLES + 2; c++) begin
            step();
            checks++;
            if (locked !== exp_locked() || cfg_ready !== exp_locked()) begin
                failures++;
                $display("FAIL reset_lock c=%0d locked=%b ready=%b want %b", c, locked, cfg_ready, exp_locked());
            end
            checks++;
            if (clken !== exp_clken()) begin
                failures++;
                $display("FAIL reset_clken c=%0d got=%b want=%b", c, clken, exp_clken());
            end
            if (locked === 1'b1 && first_hi < 0) begin
                first_hi = c;
                checks++;
                if (clken !== 3'b111) begin
                    failures++;
                    $display("FAIL first_locked_clken got=%b want=111", clken);
                end
            end
        end
        checks++;
        if (first_hi != LOCK_CYCLES - 1) begin
            failures++;
            $display("FAIL lock_latency got_idx=%0d want_idx=%0d", first_hi, LOCK_CYCLES - 1);
        end
    endtask

    task automatic test_defaults();
        int cnt [NUM_CH];
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            checks++;
            if (clken !== exp_clken() || locked !== 1'b1) begin
                failures++;
                $display("FAIL defaults_clken c=%0d got=%b/%b want=%b/1", c, clken, locked, exp_clken());
            end
            for (int i = 0; i < NUM_CH; i++) if (clken[i] === 1'b1) cnt[i]++;
        end
        checks++;
        if (cnt[0] != 2 || cnt[1] != 6 || cnt[2] != 3) begin
            failures++;
            $display("FAIL defaults_rate got=%0d,%0d,%0d want=2,6,3", cnt[0], cnt[1], cnt[2]);
        end
    endtask

    task automatic test_write_ch1();
        int hits[$];
        int t;
        int first_hi;
        t = -1; first_hi = -1;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4; cfg_phase = 8'd2;
        step();
        cfg_we = 1'b0;
        checks++;
        if (locked !== 1'b0 || cfg_ready !== 1'b0 || clken !== '0) begin
            failures++;
            $display("FAIL write_unlock locked=%b ready=%b clken=%b want 0/0/000", locked, cfg_ready, clken);
        end
        for (int c = 1; c < LOCK_CYCLES + 12; c++) begin
            step();
            checks++;
            if (locked !== exp_locked() || clken !== exp_clken()) begin
                failures++;
                $display("FAIL write_ch1 c=%0d got=%b/%b want=%b/%b", c, locked, clken, exp_locked(), exp_clken());
            end
            if (locked === 1'b1) begin
                t++;
                if (t == 0) first_hi = c;
                if (clken[1] === 1'b1) hits.push_back(t);
            end
        end
        checks++;
        if (first_hi != LOCK_CYCLES) begin
            failures++;
            $display("FAIL write_relock got=%0d want=%0d", first_hi, LOCK_CYCLES);
        end
        checks++;
        if (hits.size() != 3 || hits[0] != 2 || hits[1] != 6 || hits[2] != 10) begin
            failures++;
            $display("FAIL write_ch1_hits got_n=%0d want 2,6,10", hits.size());
        end
    endtask

    task automatic test_div_zero();
        logic [DIV_W-1:0] dv [2];
        logic [DIV_W-1:0] ph [2];
        dv[0] = 8'd0; ph[0] = 8'd5;
        dv[1] = 8'd3; ph[1] = 8'd9;
        for (int w = 0; w < 2; w++) begin
            int hits[$];
            int t;
            t = -1;
            cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = dv[w]; cfg_phase = ph[w];
            step();
            cfg_we = 1'b0;
            for (int c = 1; c < LOCK_CYCLES + 9; c++) begin
                step();
                checks++;
                if (locked !== exp_locked() || clken !== exp_clken()) begin
                    failures++;
                    $display("FAIL divz w=%0d c=%0d got=%b/%b want=%b/%b", w, c, locked, clken, exp_locked(), exp_clken());
                end
                if (locked === 1'b1) begin
                    t++;
                    if (clken[2] === 1'b1) hits.push_back(t);
                end
            end
            checks++;
            if (w == 0 && hits.size() != 9) begin
                failures++;
                $display("FAIL div0_every_cycle got=%0d want=9", hits.size());
            end else if (w == 1 && (hits.size() != 3 || hits[0] != 2 || hits[1] != 5 || hits[2] != 8)) begin
                failures++;
                $display("FAIL div3_phase_clamp got_n=%0d want 2,5,8", hits.size());
            end
        end
    endtask

    task automatic test_ignored();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7; cfg_phase = 8'd1;
        step();
        for (int c = 0; c < LOCK_CYCLES + 4; c++) begin
            cfg_we = (c < LOCK_CYCLES - 4);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_div = 8'($urandom); cfg_phase = 8'($urandom);
            step();
            checks++;
            if (locked !== exp_locked() || clken !== exp_clken()) begin
                failures++;
                $display("FAIL settle_we c=%0d got=%b/%b want=%b/%b", c, locked, clken, exp_locked(), exp_clken());
            end
        end
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2; cfg_phase = 8'd0;
        step();
        cfg_we = 1'b0;
        checks++;
        if (locked !== 1'b1 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL bad_ch_relock locked=%b ready=%b want 1/1", locked, cfg_ready);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (clken !== exp_clken()) begin
                failures++;
                $display("FAIL bad_ch_clken c=%0d got=%b want=%b", c, clken, exp_clken());
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_hi;
        int cnt [NUM_CH];
        first_hi = -1;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd9; cfg_phase = 8'd3;
        step();
        cfg_we = 1'b0;
        repeat ($urandom_range(5, 50)) step();
        reset_n = 1'b0;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd77; cfg_phase = 8'd1;
        step();
        reset_n = 1'b1; cfg_we = 1'b0;
        for (int c = 0; c < LOCK_CYCLES + 59; c++) begin
            step();
            checks++;
            if (locked !== exp_locked() || clken !== exp_clken()) begin
                failures++;
                $display("FAIL reset_mid c=%0d got=%b/%b want=%b/%b", c, locked, clken, exp_locked(), exp_clken());
            end
            if (locked === 1'b1 && first_hi < 0) first_hi = c;
            for (int i = 0; i < NUM_CH; i++) if (clken[i] === 1'b1) cnt[i]++;
        end
        checks++;
        if (first_hi != LOCK_CYCLES - 1 || cnt[0] != 2 || cnt[1] != 6 || cnt[2] != 3) begin
            failures++;
            $display("FAIL reset_mid_restore lock_idx=%0d cnt=%0d,%0d,%0d want %0d 2,6,3",
                     first_hi, cnt[0], cnt[1], cnt[2], LOCK_CYCLES - 1);
        end
    endtask

`ifdef LCD_CLKEN_DUTY_EN
    task automatic test_duty();
        logic [9:0] pat;
        int t;
        pat = '0; t = -1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5; cfg_phase = 8'd0;
        step();
        cfg_we = 1'b0;
        for (int c = 1; c < LOCK_CYCLES + 10; c++) begin
            step();
            checks++;
            if (clk_div !== exp_clkdiv()) begin
                failures++;
                $display("FAIL clk_div c=%0d got=%b want=%b", c, clk_div, exp_clkdiv());
            end
            if (locked === 1'b1) begin
                t++;
                pat[t] = clk_div[0];
            end
        end
        checks++;
        if (pat !== 10'b0011100111) begin
            failures++;
            $display("FAIL clk_div_div5 got=%b want=0011100111", pat);
        end
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int run;
            int sel;
            run = $urandom_range(0, 90);
            for (int c = 0; c <= run; c++) begin
                if (c == run) begin
                    cfg_we = 1'b1;
                    cfg_ch = 2'($urandom_range(0, 3));
                    sel = $urandom_range(0, 4);
                    cfg_div = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'd255 : 8'($urandom);
                    cfg_phase = 8'($urandom);
                end else begin
                    cfg_we = ($urandom_range(0, 31) == 0);
                    cfg_ch = 2'($urandom_range(0, 3));
                    cfg_div = 8'($urandom); cfg_phase = 8'($urandom);
                end
                step();
                cfg_we = 1'b0;
                checks++;
                if (locked !== exp_locked() || cfg_ready !== exp_locked() || clken !== exp_clken()) begin
                    failures++;
                    $display("FAIL random it=%0d c=%0d got=%b/%b/%b want=%b/%b", it, c, locked, cfg_ready, clken,
                             exp_locked(), exp_clken());
                end
`ifdef LCD_CLKEN_DUTY_EN
                checks++;
                if (clk_div !== exp_clkdiv()) begin
                    failures++;
                    $display("FAIL random_clk_div it=%0d got=%b want=%b", it, clk_div, exp_clkdiv());
                end
`endif
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_write_ch1();
        test_div_zero();
        test_ignored();
        test_reset_mid();
`ifdef LCD_CLKEN_DUTY_EN
        test_duty();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
